// File: rtl/uart_pkg.sv
// Shared constants for the UART AXI4-Lite register block: offsets, response
// codes, CONTROL/STATUS bit positions and the channel FSM state types.
package uart_pkg;

  localparam logic [31:0] OFF_RX_DATA = 32'h00;
  localparam logic [31:0] OFF_TX_DATA = 32'h04;
  localparam logic [31:0] OFF_STATUS  = 32'h08;
  localparam logic [31:0] OFF_CONTROL = 32'h0C;
  localparam logic [31:0] OFF_SCRATCH = 32'h10;
  localparam logic [31:0] OFF_IRQ_EN  = 32'h14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int CTRL_RX_EN       = 0;
  localparam int CTRL_TX_EN       = 1;
  localparam int CTRL_RX_FIFO_RST = 4;
  localparam int CTRL_TX_FIFO_RST = 5;

  localparam int STAT_RX_EMPTY = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_OVERRUN  = 4;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  typedef enum logic [2:0] {
    SEL_RX_DATA, SEL_TX_DATA, SEL_STATUS, SEL_CONTROL, SEL_SCRATCH, SEL_IRQ_EN, SEL_NONE
  } reg_sel_t;

endpackage

// File: rtl/axi4l_uart_decode.sv
// Combinational address decoder for the UART register window.
// 0x14 (IRQ_ENABLE) is only mapped when UART_REGS_IRQ_EN is defined.
module axi4l_uart_decode
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] BASE_MASK = ADDR_WIDTH'(32'h0000_0FFF)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output reg_sel_t              sel,
  output logic                  rd_err,
  output logic                  wr_err
);

  logic [ADDR_WIDTH-1:0] word;

  assign hit  = (addr & ~BASE_MASK) == (BASE_ADDR & ~BASE_MASK);
  // Byte lane bits are ignored: all registers are word aligned.
  assign word = addr & BASE_MASK & ~ADDR_WIDTH'(3);

  always_comb begin
    sel = SEL_NONE;
    if (word == ADDR_WIDTH'(OFF_RX_DATA))      sel = SEL_RX_DATA;
    else if (word == ADDR_WIDTH'(OFF_TX_DATA)) sel = SEL_TX_DATA;
    else if (word == ADDR_WIDTH'(OFF_STATUS))  sel = SEL_STATUS;
    else if (word == ADDR_WIDTH'(OFF_CONTROL)) sel = SEL_CONTROL;
    else if (word == ADDR_WIDTH'(OFF_SCRATCH)) sel = SEL_SCRATCH;
`ifdef UART_REGS_IRQ_EN
    else if (word == ADDR_WIDTH'(OFF_IRQ_EN))  sel = SEL_IRQ_EN;
`endif
  end

  assign rd_err = hit && (sel == SEL_NONE || sel == SEL_TX_DATA);
  assign wr_err = hit && (sel == SEL_NONE || sel == SEL_RX_DATA || sel == SEL_STATUS);

endmodule

// File: rtl/axi4l_uart_regs.sv
// AXI4-Lite register file for the UART: data, status, control, scratch and
// FIFO strobes. Define UART_REGS_IRQ_EN to add IRQ_ENABLE (0x14) and irq.
module axi4l_uart_regs
  import uart_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_ADDR = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_MASK = AXI_ADDR_WIDTH'(32'h0000_0FFF)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      tx_wr_en,
  output logic [7:0]                tx_wr_data,
  input  logic                      tx_full,
  input  logic                      tx_empty,
  output logic                      rx_rd_en,
  input  logic [7:0]                rx_rd_data,
  input  logic                      rx_full,
  input  logic                      rx_empty,
  input  logic                      rx_overrun,
  output logic                      rx_enable,
  output logic                      tx_enable,
  output logic                      rx_fifo_rst,
  output logic                      tx_fifo_rst,
  output logic                      irq
);

  if (AXI_DATA_WIDTH != 32) begin : g_width_check
    $error("axi4l_uart_regs supports only AXI_DATA_WIDTH = 32");
  end

  wstate_t wstate;
  rstate_t rstate;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_reg, wr_addr;
  logic [31:0] w_data_reg, wr_data, scratch_reg, rd_data;
  logic [3:0]  w_strb_reg, wr_strb;
  logic aw_hs, w_hs, ar_hs, wr_fire, wr_ok, status_clr, overrun_sticky_reg;
  logic wr_hit, wr_err, rd_hit, rd_err;
  logic [1:0] wr_resp, rd_resp;
  reg_sel_t wr_sel, rd_sel;

  axi4l_uart_decode #(.ADDR_WIDTH(AXI_ADDR_WIDTH), .BASE_ADDR(AXI_BASE_ADDR), .BASE_MASK(AXI_BASE_MASK))
    u_wr_decode (.addr(wr_addr), .hit(wr_hit), .sel(wr_sel), .rd_err(), .wr_err(wr_err));
  axi4l_uart_decode #(.ADDR_WIDTH(AXI_ADDR_WIDTH), .BASE_ADDR(AXI_BASE_ADDR), .BASE_MASK(AXI_BASE_MASK))
    u_rd_decode (.addr(s_axi_araddr), .hit(rd_hit), .sel(rd_sel), .rd_err(rd_err), .wr_err());

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // The half that arrived first is replayed from its holding register.
  assign wr_addr = (wstate == W_ADDR) ? aw_addr_reg : s_axi_awaddr;
  assign wr_data = (wstate == W_DATA) ? w_data_reg : s_axi_wdata;
  assign wr_strb = (wstate == W_DATA) ? w_strb_reg : s_axi_wstrb;

  always_comb begin
    wr_fire = 1'b0;
    case (wstate)
      W_IDLE:  wr_fire = aw_hs && w_hs;
      W_ADDR:  wr_fire = w_hs;
      W_DATA:  wr_fire = aw_hs;
      default: wr_fire = 1'b0;
    endcase
  end

  always_comb begin
    if (!wr_hit)                                       wr_resp = RESP_DECERR;
    else if (wr_err || (wr_sel == SEL_TX_DATA && tx_full)) wr_resp = RESP_SLVERR;
    else                                               wr_resp = RESP_OKAY;
  end

  assign wr_ok      = wr_fire && (wr_resp == RESP_OKAY);
  assign tx_wr_en   = wr_ok && (wr_sel == SEL_TX_DATA) && wr_strb[0];
  assign tx_wr_data = wr_data[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate        <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_addr_reg   <= '0;
      w_data_reg    <= '0;
      w_strb_reg    <= '0;
    end else if (wr_fire) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b1;
      s_axi_bresp   <= wr_resp;
      wstate        <= W_RESP;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr_reg   <= s_axi_awaddr;
            s_axi_awready <= 1'b0;
            wstate        <= W_ADDR;
          end else if (w_hs) begin
            w_data_reg   <= s_axi_wdata;
            w_strb_reg   <= s_axi_wstrb;
            s_axi_wready <= 1'b0;
            wstate       <= W_DATA;
          end else begin
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            wstate        <= W_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_rd_en   = ar_hs && (rd_sel == SEL_RX_DATA) && (rd_resp == RESP_OKAY);
  assign status_clr = ar_hs && (rd_sel == SEL_STATUS) && (rd_resp == RESP_OKAY);

`ifdef UART_REGS_IRQ_EN
  logic [2:0] irq_en_reg;
  logic       irq_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_en_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr_ok && wr_sel == SEL_IRQ_EN && wr_strb[0]) irq_en_reg <= wr_data[2:0];
      irq_reg <= |(irq_en_reg & {overrun_sticky_reg, tx_empty, !rx_empty});
    end
  end
  assign irq = irq_reg;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    if (!rd_hit) begin
      rd_resp = RESP_DECERR;
    end else if (rd_err || (rd_sel == SEL_RX_DATA && rx_empty)) begin
      rd_resp = RESP_SLVERR;
    end else begin
      rd_resp = RESP_OKAY;
      case (rd_sel)
        SEL_RX_DATA: rd_data[7:0] = rx_rd_data;
        SEL_STATUS: begin
          rd_data[STAT_RX_EMPTY] = rx_empty;
          rd_data[STAT_RX_FULL]  = rx_full;
          rd_data[STAT_TX_EMPTY] = tx_empty;
          rd_data[STAT_TX_FULL]  = tx_full;
          rd_data[STAT_OVERRUN]  = overrun_sticky_reg;
        end
        SEL_CONTROL: begin
          rd_data[CTRL_RX_EN] = rx_enable;
          rd_data[CTRL_TX_EN] = tx_enable;
        end
        SEL_SCRATCH: rd_data = scratch_reg;
`ifdef UART_REGS_IRQ_EN
        SEL_IRQ_EN:  rd_data[2:0] = irq_en_reg;
`endif
        default:     rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstate        <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= rd_data;
            s_axi_rresp   <= rd_resp;
            rstate        <= R_RESP;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        default: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            rstate        <= R_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_enable          <= 1'b0;
      tx_enable          <= 1'b0;
      rx_fifo_rst        <= 1'b0;
      tx_fifo_rst        <= 1'b0;
      scratch_reg        <= '0;
      overrun_sticky_reg <= 1'b0;
    end else begin
      rx_fifo_rst <= 1'b0;
      tx_fifo_rst <= 1'b0;
      if (wr_ok && wr_sel == SEL_CONTROL && wr_strb[0]) begin
        rx_enable   <= wr_data[CTRL_RX_EN];
        tx_enable   <= wr_data[CTRL_TX_EN];
        rx_fifo_rst <= wr_data[CTRL_RX_FIFO_RST];
        tx_fifo_rst <= wr_data[CTRL_TX_FIFO_RST];
      end
      if (wr_ok && wr_sel == SEL_SCRATCH) begin
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) scratch_reg[8*b +: 8] <= wr_data[8*b +: 8];
      end
      // A new overrun in the same cycle as the clearing read stays visible.
      if (rx_overrun)      overrun_sticky_reg <= 1'b1;
      else if (status_clr) overrun_sticky_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4l_uart_regs.sv
// Directed bench for axi4l_uart_regs: a vector table of register accesses
// followed by hand-written multi-cycle sequences.
module tb_axi4l_uart_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic        tx_wr_en, tx_full, tx_empty, rx_rd_en, rx_full, rx_empty, rx_overrun;
  logic [7:0]  tx_wr_data, rx_rd_data;
  logic        rx_enable, tx_enable, rx_fifo_rst, tx_fifo_rst, irq;

  axi4l_uart_regs dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_empty(tx_empty),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_full(rx_full), .rx_empty(rx_empty),
    .rx_overrun(rx_overrun), .rx_enable(rx_enable), .tx_enable(tx_enable),
    .rx_fifo_rst(rx_fifo_rst), .tx_fifo_rst(tx_fifo_rst), .irq(irq)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] OK = 2'b00, SLV = 2'b10, DEC = 2'b11;

  int n_checks = 0;
  int n_fail   = 0;

  // Event counters sampled mid-cycle; sequences compare deltas.
  int tx_cnt = 0, rx_cnt = 0, b_cnt = 0, rxr_cnt = 0, txr_cnt = 0;
  logic [7:0] tx_last = '0;
  always @(negedge clk) begin
    if (tx_wr_en) begin tx_cnt++; tx_last = tx_wr_data; end
    if (rx_rd_en) rx_cnt++;
    if (s_axi_bvalid && s_axi_bready) b_cnt++;
    if (rx_fifo_rst) rxr_cnt++;
    if (tx_fifo_rst) txr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
    logic aw_done, w_done, b_done;
    aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0; resp = 2'b01;
    s_axi_bready = 1'b1;
    fork
      begin
        repeat (aw_dly) @(posedge clk);
        #1; s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
        for (int i = 0; i < 50 && !aw_done; i++) begin
          @(negedge clk);
          if (s_axi_awready) begin @(posedge clk); #1; aw_done = 1'b1; end
        end
        s_axi_awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(posedge clk);
        #1; s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        for (int i = 0; i < 50 && !w_done; i++) begin
          @(negedge clk);
          if (s_axi_wready) begin @(posedge clk); #1; w_done = 1'b1; end
        end
        s_axi_wvalid = 1'b0;
      end
    join
    for (int i = 0; i < 50 && !b_done; i++) begin
      @(negedge clk);
      if (s_axi_bvalid) begin resp = s_axi_bresp; @(posedge clk); #1; b_done = 1'b1; end
    end
    s_axi_bready = 1'b0;
    if (!(aw_done && w_done && b_done)) check("write_timeout", {aw_done, w_done, b_done}, 3'b111);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold, input logic [31:0] exp_hold,
                          output logic [31:0] data, output logic [1:0] resp);
    logic ar_done, r_done;
    ar_done = 1'b0; r_done = 1'b0; data = '0; resp = 2'b01;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 50 && !ar_done; i++) begin
      @(negedge clk);
      if (s_axi_arready) begin @(posedge clk); #1; ar_done = 1'b1; end
    end
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 50 && !r_done; i++) begin
      @(negedge clk);
      if (s_axi_rvalid) begin data = s_axi_rdata; resp = s_axi_rresp; r_done = 1'b1; end
    end
    if (!(ar_done && r_done)) check("read_timeout", {ar_done, r_done}, 2'b11);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("rvalid_hold", s_axi_rvalid, 1'b1);
      check("rdata_hold", s_axi_rdata, exp_hold);
    end
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
  endtask

  task automatic pulse_overrun();
    rx_overrun = 1'b1;
    @(posedge clk); #1;
    rx_overrun = 1'b0;
  endtask

  typedef struct packed {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int t0, r0, b0, rr0, tr0;

    // Idle FIFO view: RX empty, TX empty, nothing full.
    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; tx_full = 1'b0; tx_empty = 1'b1; rx_rd_data = 8'h00;
    rx_full = 1'b0; rx_empty = 1'b1; rx_overrun = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl_outs",
          {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, tx_wr_en,
           rx_rd_en, rx_fifo_rst, tx_fifo_rst, irq, rx_enable, tx_enable}, 12'h000);
    check("reset_resps", {s_axi_bresp, s_axi_rresp}, 4'h0);
    check("reset_rdata", s_axi_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    vecs.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, OK,  32'h0});
    vecs.push_back('{1'b1, 32'h10,   32'h00005500, 4'h2, OK,  32'h0});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, OK,  32'hDEAD55EF});
    vecs.push_back('{1'b1, 32'h13,   32'h11223344, 4'h8, OK,  32'h0});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, OK,  32'h11AD55EF});
    vecs.push_back('{1'b1, 32'h0C,   32'h00000033, 4'hF, OK,  32'h0});
    vecs.push_back('{1'b0, 32'h0C,   32'h0,        4'h0, OK,  32'h00000003});
    vecs.push_back('{1'b0, 32'h1000, 32'h0,        4'h0, DEC, 32'h0});
    vecs.push_back('{1'b1, 32'h1010, 32'h12345678, 4'hF, DEC, 32'h0});
    vecs.push_back('{1'b0, 32'h18,   32'h0,        4'h0, SLV, 32'h0});
    vecs.push_back('{1'b1, 32'h18,   32'h12345678, 4'hF, SLV, 32'h0});
    vecs.push_back('{1'b1, 32'h08,   32'hFFFFFFFF, 4'hF, SLV, 32'h0});
    vecs.push_back('{1'b0, 32'h08,   32'h0,        4'h0, OK,  32'h00000005});
    vecs.push_back('{1'b0, 32'h04,   32'h0,        4'h0, SLV, 32'h0});
    vecs.push_back('{1'b1, 32'h00,   32'h000000AA, 4'hF, SLV, 32'h0});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, OK,  32'h11AD55EF});
`ifdef UART_REGS_IRQ_EN
    vecs.push_back('{1'b0, 32'h14,   32'h0,        4'h0, OK,  32'h0});
`else
    vecs.push_back('{1'b0, 32'h14,   32'h0,        4'h0, SLV, 32'h0});
    vecs.push_back('{1'b1, 32'h14,   32'h00000007, 4'hF, SLV, 32'h0});
`endif

    t0 = tx_cnt; r0 = rx_cnt; rr0 = rxr_cnt; tr0 = txr_cnt;
    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].is_wr) begin
        axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb, 0, 0, resp);
        $display("vec %0d: WR addr=%h data=%h strb=%h bresp=%b", v, vecs[v].addr, vecs[v].data, vecs[v].strb, resp);
        check($sformatf("vec%0d_bresp", v), resp, vecs[v].resp);
      end else begin
        axi_read(vecs[v].addr, 0, 32'h0, data, resp);
        $display("vec %0d: RD addr=%h rdata=%h rresp=%b", v, vecs[v].addr, data, resp);
        check($sformatf("vec%0d_rresp", v), resp, vecs[v].resp);
        check($sformatf("vec%0d_rdata", v), data, vecs[v].rdata);
      end
    end
    check("ctrl_enables", {tx_enable, rx_enable}, 2'b11);
    check("fifo_rst_pulses", {rxr_cnt - rr0, txr_cnt - tr0}, {32'd1, 32'd1});
    check("table_no_push", tx_cnt - t0, 0);
    check("table_no_pop", rx_cnt - r0, 0);

    // TX push with AW leading W by 3 cycles, then W leading AW.
    t0 = tx_cnt; b0 = b_cnt;
    axi_write(32'h04, 32'h00000041, 4'hF, 0, 3, resp);
    $display("tx aw-first: bresp=%b pushes=%0d byte=%h", resp, tx_cnt - t0, tx_last);
    check("tx_awfirst_bresp", resp, OK);
    check("tx_awfirst_pushes", tx_cnt - t0, 1);
    check("tx_awfirst_byte", tx_last, 8'h41);
    check("tx_awfirst_bcount", b_cnt - b0, 1);
    t0 = tx_cnt; b0 = b_cnt;
    axi_write(32'h04, 32'h00000042, 4'hF, 3, 0, resp);
    $display("tx w-first: bresp=%b pushes=%0d byte=%h", resp, tx_cnt - t0, tx_last);
    check("tx_wfirst_bresp", resp, OK);
    check("tx_wfirst_pushes", tx_cnt - t0, 1);
    check("tx_wfirst_byte", tx_last, 8'h42);
    check("tx_wfirst_bcount", b_cnt - b0, 1);

    tx_full = 1'b1; t0 = tx_cnt;
    axi_write(32'h04, 32'h00000043, 4'hF, 0, 0, resp);
    $display("tx full: bresp=%b pushes=%0d", resp, tx_cnt - t0);
    check("tx_full_bresp", resp, SLV);
    check("tx_full_pushes", tx_cnt - t0, 0);
    tx_full = 1'b0; t0 = tx_cnt;
    axi_write(32'h04, 32'h00000044, 4'h0, 0, 0, resp);
    $display("tx strb0: bresp=%b pushes=%0d", resp, tx_cnt - t0);
    check("tx_strb0_bresp", resp, OK);
    check("tx_strb0_pushes", tx_cnt - t0, 0);

    // RX pops: empty FIFO, then a byte held through 4 cycles of rready low.
    r0 = rx_cnt;
    axi_read(32'h00, 0, 32'h0, data, resp);
    $display("rx empty: rdata=%h rresp=%b pops=%0d", data, resp, rx_cnt - r0);
    check("rx_empty_rresp", resp, SLV);
    check("rx_empty_rdata", data, 32'h0);
    check("rx_empty_pops", rx_cnt - r0, 0);
    rx_rd_data = 8'h5A; rx_empty = 1'b0; r0 = rx_cnt;
    axi_read(32'h00, 4, 32'h0000005A, data, resp);
    $display("rx byte: rdata=%h rresp=%b pops=%0d", data, resp, rx_cnt - r0);
    check("rx_byte_rresp", resp, OK);
    check("rx_byte_rdata", data, 32'h0000005A);
    check("rx_byte_pops", rx_cnt - r0, 1);
    rx_empty = 1'b1;

    // Overrun sticky, and the interrupt it can raise.
`ifdef UART_REGS_IRQ_EN
    axi_write(32'h14, 32'h00000004, 4'hF, 0, 0, resp);
    check("irq_en_bresp", resp, OK);
    axi_read(32'h14, 0, 32'h0, data, resp);
    check("irq_en_rdata", data, 32'h4);
    check("irq_idle", irq, 1'b0);
`endif
    pulse_overrun();
    repeat (3) @(posedge clk); #1;
`ifdef UART_REGS_IRQ_EN
    check("irq_after_overrun", irq, 1'b1);
`else
    check("irq_tied_low", irq, 1'b0);
`endif
    axi_read(32'h08, 0, 32'h0, data, resp);
    $display("status after overrun: rdata=%h rresp=%b", data, resp);
    check("status_sticky_set", data, 32'h00000015);
    repeat (3) @(posedge clk); #1;
`ifdef UART_REGS_IRQ_EN
    check("irq_after_clear", irq, 1'b0);
`endif
    axi_read(32'h08, 0, 32'h0, data, resp);
    $display("status after clear: rdata=%h rresp=%b", data, resp);
    check("status_sticky_clr", data, 32'h00000005);

    // Reset in the middle of a read response drops it.
    s_axi_araddr = 32'h10; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_axi_arready) break;
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    @(negedge clk);
    check("rvalid_before_rst", s_axi_rvalid, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rvalid_after_rst", s_axi_rvalid, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    axi_read(32'h10, 0, 32'h0, data, resp);
    $display("scratch after reset: rdata=%h rresp=%b", data, resp);
    check("scratch_after_rst", data, 32'h0);
    axi_read(32'h0C, 0, 32'h0, data, resp);
    $display("control after reset: rdata=%h rresp=%b", data, resp);
    check("control_after_rst", data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
